// File: rtl/rs_hs_pipeline_tail_fifo_if.sv
// Handshake bundle between the last relay-station body stage, the tail FIFO and its consumer.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface rs_hs_pipeline_tail_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din_data;
    logic                  credit_ready;
    logic                  dout_valid;
    logic [DATA_WIDTH-1:0] dout_data;
    logic                  dout_ready;

    modport slave (
        input  din_valid,
        input  din_data,
        output credit_ready,
        output dout_valid,
        output dout_data,
        input  dout_ready
    );

    modport master (
        output din_valid,
        output din_data,
        input  credit_ready,
        input  dout_valid,
        input  dout_data,
        output dout_ready
    );
endinterface

// File: rtl/rs_hs_pipeline_tail_fifo.sv
// Tail of the relay-station pipeline: absorbs unthrottled beats, returns a registered credit
// ready upstream, and presents a first-word-fall-through stream to the consumer.
module rs_hs_pipeline_tail_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 24,
    parameter int unsigned GRACE_PERIOD = 17,
    parameter int unsigned REAL_DEPTH   = GRACE_PERIOD + DEPTH + 4,
    parameter int unsigned THRESHOLD    = REAL_DEPTH - GRACE_PERIOD,
    parameter int unsigned CNT_WIDTH    = $clog2(REAL_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    rs_hs_pipeline_tail_fifo_if.slave    bus,
    output logic [CNT_WIDTH-1:0]         occupancy,
    output logic                         overflow
);

    localparam int unsigned PTR_WIDTH = $clog2(REAL_DEPTH);
    localparam logic [PTR_WIDTH-1:0] PtrLast = PTR_WIDTH'(REAL_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(REAL_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CntThr  = CNT_WIDTH'(THRESHOLD);

    logic [DATA_WIDTH-1:0] mem_q [REAL_DEPTH];

    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 credit_q, credit_d;
    logic                 overflow_q, overflow_d;
    logic                 rd, wr;

    always_comb begin
        rd = (count_q != '0) & bus.dout_ready;
        // A full FIFO still takes a beat if the consumer frees a slot on the same edge.
        wr = bus.din_valid & ((count_q < CntFull) | rd);

        rd_ptr_d = rd_ptr_q;
        if (rd) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        if (wr) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end

        count_d = count_q;
        unique case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        credit_d   = (count_d < CntThr);
        overflow_d = overflow_q | (bus.din_valid & ~wr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally left out of reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= bus.din_data;
        end
    end

    assign bus.credit_ready = credit_q;
    assign bus.dout_valid   = (count_q != '0);
    assign bus.dout_data    = mem_q[rd_ptr_q];
    assign occupancy        = count_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_rs_hs_pipeline_tail_fifo.sv
// Directed bench for the relay-station tail FIFO: a vector table for basic handshakes plus
// hand-written fill/overflow/drain, wrap-around streaming and mid-stream reset sequences.
module tb_rs_hs_pipeline_tail_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] occupancy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    rs_hs_pipeline_tail_fifo_if #(.DATA_WIDTH(32)) bus ();

    rs_hs_pipeline_tail_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [31:0] dd;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [5:0]  eo;
        logic        ec;
        logic        eovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        reset = 1'b0;
        #3;
        check("rst_credit", {31'b0, bus.credit_ready}, 32'd0);
        check("rst_valid", {31'b0, bus.dout_valid}, 32'd0);
        check("rst_occ", {26'b0, occupancy}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_credit_up", {31'b0, bus.credit_ready}, 32'd1);
    endtask

    task automatic push(input logic [31:0] d);
        bus.din_valid  = 1'b1;
        bus.din_data   = d;
        bus.dout_ready = 1'b0;
        tick();
        bus.din_valid  = 1'b0;
    endtask

    initial begin
        int exp_next;
        int sent;
        int cyc;

        bus.din_valid  = 1'b0;
        bus.din_data   = '0;
        bus.dout_ready = 1'b0;

        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 32'hA5A5_0001, 6'd1, 1'b1, 1'b0};
        for (int i = 1; i <= 5; i++) begin
            vecs[i] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001, 6'd1, 1'b1, 1'b0};
        end
        vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 6'd0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0011, 1'b0, 1'b1, 32'h0000_0011, 6'd1, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_0022, 1'b1, 1'b1, 32'h0000_0022, 6'd1, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 6'd0, 1'b1, 1'b0};

        // Reset, idle, then the single-beat vectors.
        #2;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        check("idle_valid", {31'b0, bus.dout_valid}, 32'd0);
        check("idle_occ", {26'b0, occupancy}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            bus.din_valid  = vecs[i].dv;
            bus.din_data   = vecs[i].dd;
            bus.dout_ready = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_valid", i), {31'b0, bus.dout_valid}, {31'b0, vecs[i].ev});
            if (vecs[i].ev) check($sformatf("v%0d_data", i), bus.dout_data, vecs[i].ed);
            check($sformatf("v%0d_occ", i), {26'b0, occupancy}, {26'b0, vecs[i].eo});
            check($sformatf("v%0d_credit", i), {31'b0, bus.credit_ready}, {31'b0, vecs[i].ec});
            check($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].eovf});
        end
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;

        // Fill to the threshold and then through the grace region.
        do_reset();
        for (int i = 0; i < 45; i++) begin
            push(32'd100 + i);
            check($sformatf("fill%0d_occ", i), {26'b0, occupancy}, i + 1);
            check($sformatf("fill%0d_credit", i), {31'b0, bus.credit_ready},
                  (i + 1 < 28) ? 32'd1 : 32'd0);
        end
        check("full_ovf", {31'b0, overflow}, 32'd0);

        // Write and read together at full: accepted, count holds, no drop.
        bus.din_valid  = 1'b1;
        bus.din_data   = 32'h0000_0055;
        bus.dout_ready = 1'b1;
        check("simul_head", bus.dout_data, 32'd100);
        tick();
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        check("simul_occ", {26'b0, occupancy}, 32'd45);
        check("simul_ovf", {31'b0, overflow}, 32'd0);

        // Extra beat into a stalled full FIFO is dropped and flagged.
        push(32'hDEAD_BEEF);
        check("drop_occ", {26'b0, occupancy}, 32'd45);
        check("drop_ovf", {31'b0, overflow}, 32'd1);
        tick();
        check("drop_ovf_sticky", {31'b0, overflow}, 32'd1);

        for (int k = 0; k < 45; k++) begin
            bus.dout_ready = 1'b1;
            check($sformatf("drain%0d_data", k), bus.dout_data,
                  (k < 44) ? 32'd101 + k : 32'h0000_0055);
            tick();
            check($sformatf("drain%0d_credit", k), {31'b0, bus.credit_ready},
                  (44 - k < 28) ? 32'd1 : 32'd0);
        end
        bus.dout_ready = 1'b0;
        check("drain_empty", {31'b0, bus.dout_valid}, 32'd0);
        check("drain_occ", {26'b0, occupancy}, 32'd0);
        check("drain_ovf_sticky", {31'b0, overflow}, 32'd1);

        // Streaming with random consumer stalls across several pointer wraps.
        do_reset();
        exp_next = 0;
        sent = 0;
        cyc = 0;
        while (exp_next < 100 && cyc < 3000) begin
            bus.din_valid  = bus.credit_ready && (sent < 100);
            bus.din_data   = sent;
            bus.dout_ready = ($urandom_range(0, 2) != 0);
            if (bus.dout_valid && bus.dout_ready) begin
                if (bus.dout_data !== exp_next) begin
                    check($sformatf("stream%0d_data", exp_next), bus.dout_data, exp_next);
                end else begin
                    checks++;
                end
                exp_next++;
            end
            if (bus.din_valid) sent++;
            tick();
            cyc++;
        end
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        check("stream_count", exp_next, 32'd100);
        check("stream_ovf", {31'b0, overflow}, 32'd0);

        // Force an overflow, then reset mid-stream: everything must clear at once.
        for (int i = 0; i < 46; i++) push(i);
        check("pre_rst_ovf", {31'b0, overflow}, 32'd1);
        bus.din_valid = 1'b1;
        bus.din_data  = 32'h1234_5678;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, bus.dout_valid}, 32'd0);
        check("mid_rst_occ", {26'b0, occupancy}, 32'd0);
        check("mid_rst_credit", {31'b0, bus.credit_ready}, 32'd0);
        check("mid_rst_ovf", {31'b0, overflow}, 32'd0);
        bus.din_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_credit", {31'b0, bus.credit_ready}, 32'd1);
        check("post_rst_occ", {26'b0, occupancy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_hs_pipeline_tail_fifo.md
Name: rs_hs_pipeline_tail_fifo

Overview:
- Receiving end of the relay-station handshake pipeline.
- Upstream body stages forward valid/data with no per-stage backpressure, so the block absorbs every beat still in flight.
- Raises a credit-style ready that the head stages pipeline back upstream.
- Presents a standard first-word-fall-through valid/ready stream to the consumer.

Parameters:
DATA_WIDTH, 32, payload width
DEPTH, 24, usable buffering seen by the producer
GRACE_PERIOD, 17, in-flight beats that may still arrive after ready drops (BODY_LEVEL*2 + head pipelining)
REAL_DEPTH, GRACE_PERIOD+DEPTH+4 (=45), physical storage entries
THRESHOLD, REAL_DEPTH-GRACE_PERIOD (=28), occupancy at which ready deasserts
CNT_WIDTH, $clog2(REAL_DEPTH+1) (=6), occupancy counter width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
if_din_valid  in  1  beat arriving from last body stage; no ready qualification
if_din_data  in  DATA_WIDTH  payload of arriving beat
if_credit_ready  out  1  registered ready returned toward head
if_dout_valid  out  1  FIFO non-empty
if_dout_data  out  DATA_WIDTH  head-of-FIFO payload
if_dout_ready  in  1  consumer accept
occupancy  out  CNT_WIDTH  current entry count
overflow  out  1  sticky error: a beat was dropped

Behaviour:
- Reset (reset=0, async): rd_ptr=0, wr_ptr=0, count=0, if_credit_ready=0, overflow=0, if_dout_valid=0. Storage contents are not reset; if_dout_data is don't-care while empty.
- First rising edge after reset releases: if_credit_ready goes to 1.
- Read event: rd = if_dout_valid & if_dout_ready.
- Write event: wr = if_din_valid & (count<REAL_DEPTH | rd).
  - A write into a full FIFO is accepted only when a read happens the same cycle.
- Drop: if_din_valid & ~wr. The beat is discarded, overflow set to 1 and held until reset. Pointers and count are unchanged by the dropped beat.
- Pointers: increment on their event; wrap from REAL_DEPTH-1 to 0 (non-power-of-two wrap, no modulo by bit truncation).
- count_next = count + wr - rd; occupancy=count.
- Output side:
  - if_dout_valid = (count!=0).
  - if_dout_data = mem[rd_ptr], combinational from storage (FWFT).
  - if_dout_data is stable while valid & ~ready.
- Latency: a beat written at edge N is visible on if_dout_valid/if_dout_data in the cycle after edge N.
- Empty with if_din_valid: write only, no read; valid rises next cycle. No bypass in the same cycle.
- Credit: if_credit_ready <= (count_next < THRESHOLD) on every edge.
  - Deasserts on the edge where occupancy reaches 28.
  - Reasserts on the edge where occupancy falls to 27.
  - The remaining 17 entries absorb grace beats; 4 entries are extra margin.
- Simultaneous read and write at any occupancy: count unchanged, both pointers advance.
- Reset mid-operation: all state clears immediately. In-flight stored data is lost; the bench does not check data across reset.

Test Plan:
- Reset, then idle 3 cycles -> if_credit_ready 0 during reset and 1 after the first edge; if_dout_valid=0, occupancy=0, overflow=0.
- Single write 0xA5A5_0001 with if_dout_ready=0 -> if_dout_valid=1 and data=0xA5A5_0001 the next cycle, held stable for 5 cycles. Then ready=1 for one cycle -> occupancy 0, valid 0.
- Write 28 consecutive beats with the consumer stalled -> if_credit_ready falls on the edge occupancy hits 28. Then 17 more beats -> occupancy 45, overflow=0. Drain one -> ready reasserts once occupancy ≤27.
- At occupancy 45 with the consumer stalled, one extra beat 0xDEAD_BEEF -> overflow=1 (sticky), occupancy stays 45; drained order shows 0xDEAD_BEEF absent.
- Stream 100 incrementing beats (0..99) with random consumer stalls -> output sequence exactly 0..99 across multiple pointer wraps at 44->0; overflow=0.
- At full (45), assert write and read in the same cycle -> write accepted, occupancy stays 45, no overflow. Then pulse reset low mid-stream -> immediate valid=0, occupancy=0, credit=0, overflow cleared.
